// File: rtl/rps_round_judge.sv
// Rock/paper/scissors round judge.
// Collects one move per player, judges the round (or declares a forfeit
// after a timeout), then presents matchresult around a single round_pulse
// so the downstream score counter sees a stable result on both its edges.
module rps_round_judge #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CW             = 10
) (
  input  logic       clk,
  input  logic       resetn,       // asynchronous, active-high despite the name
  input  logic       p1_valid,
  input  logic [1:0] p1_move,
  input  logic       p2_valid,
  input  logic [1:0] p2_move,
  input  logic       game_over,
  output logic       p1_ack,
  output logic       p2_ack,
  output logic [1:0] matchresult,
  output logic       round_pulse,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, HAVE1, HAVE2, JUDGE, PULSE, HOLD} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [1:0]      mv1, mv2, mv1_nx, mv2_nx, mr_nx;
  logic            ok1, ok2, acc1, acc2, tout;

  // 01 rock, 10 paper, 11 scissors; 01 draw, 10 p1 wins, 11 p2 wins
  function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
    if (a == b) return 2'b01;
    if ((a == 2'b01 && b == 2'b11) || (a == 2'b10 && b == 2'b01) ||
        (a == 2'b11 && b == 2'b10)) return 2'b10;
    return 2'b11;
  endfunction

  // Next-state, acceptance and next-result decode
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mv1_nx   = mv1;
    mv2_nx   = mv2;
    mr_nx    = matchresult;
    acc1     = 1'b0;
    acc2     = 1'b0;
    ok1      = p1_valid && (p1_move != 2'b00);
    ok2      = p2_valid && (p2_move != 2'b00);
    tout     = (cnt == CW'(TIMEOUT_CYCLES - 1));
    case (state)
      IDLE: begin
        // game_over only blocks the start of a round, never one in flight
        acc1   = ok1 && !game_over;
        acc2   = ok2 && !game_over;
        cnt_nx = '0;
        if (acc1) mv1_nx = p1_move;
        if (acc2) mv2_nx = p2_move;
        if (acc1 && acc2) begin
          state_nx = JUDGE;
          mr_nx    = judge(p1_move, p2_move);
        end else if (acc1) begin
          state_nx = HAVE1;
        end else if (acc2) begin
          state_nx = HAVE2;
        end
      end
      HAVE1: begin
        acc2   = ok2;
        cnt_nx = cnt + 1'b1;
        // a late move on the timeout edge still counts as a real move
        if (acc2) begin
          mv2_nx   = p2_move;
          state_nx = JUDGE;
          mr_nx    = judge(mv1, p2_move);
        end else if (tout) begin
          state_nx = JUDGE;
          mr_nx    = 2'b10;
        end
      end
      HAVE2: begin
        acc1   = ok1;
        cnt_nx = cnt + 1'b1;
        if (acc1) begin
          mv1_nx   = p1_move;
          state_nx = JUDGE;
          mr_nx    = judge(p1_move, mv2);
        end else if (tout) begin
          state_nx = JUDGE;
          mr_nx    = 2'b11;
        end
      end
      JUDGE:   state_nx = PULSE;
      PULSE:   state_nx = HOLD;
      HOLD: begin
        state_nx = IDLE;
        mr_nx    = 2'b00;
        mv1_nx   = 2'b00;
        mv2_nx   = 2'b00;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, counter, latched moves and registered outputs
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      mv1         <= 2'b00;
      mv2         <= 2'b00;
      matchresult <= 2'b00;
      round_pulse <= 1'b0;
      p1_ack      <= 1'b0;
      p2_ack      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      mv1         <= mv1_nx;
      mv2         <= mv2_nx;
      matchresult <= mr_nx;
      round_pulse <= (state == JUDGE);
      p1_ack      <= acc1;
      p2_ack      <= acc2;
      busy        <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_rps_round_judge.sv
// Bench for rps_round_judge: directed scenarios plus random traffic, all
// compared cycle by cycle against a round-level reference model.
module tb_rps_round_judge;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       p1_valid = 1'b0, p2_valid = 1'b0, game_over = 1'b0;
  logic [1:0] p1_move = 2'b00, p2_move = 2'b00;
  logic       p1_ack, p2_ack, round_pulse, busy;
  logic [1:0] matchresult;

  int vec = 0, err = 0;

  // reference model: latched moves (0 = none), wait count, post-judge window
  int   m1, m2, waited, post, res;
  logic e_a1, e_a2;
  logic [5:0] expv;
  logic [5:0] obs;
  assign obs = {p1_ack, p2_ack, matchresult, round_pulse, busy};

  rps_round_judge #(.TIMEOUT_CYCLES(TO), .CW(4)) dut (
    .clk(clk), .resetn(resetn),
    .p1_valid(p1_valid), .p1_move(p1_move),
    .p2_valid(p2_valid), .p2_move(p2_move),
    .game_over(game_over),
    .p1_ack(p1_ack), .p2_ack(p2_ack),
    .matchresult(matchresult), .round_pulse(round_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  // rock=1 paper=2 scissors=3: player 1 wins when it is one step "ahead" mod 3
  function automatic int ref_judge(int a, int b);
    if (a == b) return 1;
    if ((a - b + 3) % 3 == 1) return 2;
    return 3;
  endfunction

  task automatic mreset();
    m1 = 0; m2 = 0; waited = 0; post = 0; res = 0; e_a1 = 0; e_a2 = 0;
    expv = '0;
  endtask

  // drive one cycle of offers, advance the model on the edge, return at negedge
  task automatic step(input logic v1, input logic [1:0] mv1,
                      input logic v2, input logic [1:0] mv2);
    logic had;
    logic [1:0] emr;
    p1_valid = v1; p1_move = mv1; p2_valid = v2; p2_move = mv2;
    @(posedge clk);
    e_a1 = 0; e_a2 = 0;
    if (post > 0) begin
      post--;
      if (post == 0) begin res = 0; m1 = 0; m2 = 0; end
    end else begin
      had = (m1 != 0) || (m2 != 0);
      if (had || !game_over) begin
        if (p1_valid && p1_move != 0 && m1 == 0) begin e_a1 = 1; m1 = p1_move; end
        if (p2_valid && p2_move != 0 && m2 == 0) begin e_a2 = 1; m2 = p2_move; end
      end
      if (m1 != 0 && m2 != 0) begin
        res = ref_judge(m1, m2); post = 3;
      end else if (had) begin
        if (waited == TO - 1) begin res = (m1 != 0) ? 2 : 3; post = 3; end
        else waited++;
      end else if (m1 != 0 || m2 != 0) begin
        waited = 0;
      end
    end
    emr  = (post > 0) ? 2'(res) : 2'b00;
    expv = {e_a1, e_a2, emr, (post == 2), (m1 != 0 || m2 != 0 || post > 0)};
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b1; mreset();
    #1;
    vec++; if (obs !== 6'b0) begin err++; $display("FAIL reset_async: obs=%b exp=000000", obs); end
    @(negedge clk); @(negedge clk);
    vec++; if (obs !== 6'b0) begin err++; $display("FAIL reset_hold: obs=%b exp=000000", obs); end
    resetn = 1'b0;
    step(0, 0, 0, 0);
    vec++; if (obs !== expv) begin err++; $display("FAIL reset_idle: obs=%b exp=%b", obs, expv); end
  endtask

  task automatic test_simultaneous();
    int pulses = 0;
    step(1, 2'b01, 1, 2'b11);
    vec++; if (obs !== expv) begin err++; $display("FAIL simul_accept: obs=%b exp=%b", obs, expv); end
    vec++; if ({p1_ack, p2_ack, matchresult, round_pulse} !== 5'b11100)
      begin err++; $display("FAIL simul_result: obs=%b exp=11100", {p1_ack, p2_ack, matchresult, round_pulse}); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      pulses += round_pulse;
      vec++; if (obs !== expv) begin err++; $display("FAIL simul_post%0d: obs=%b exp=%b", i, obs, expv); end
    end
    vec++; if (pulses != 1 || matchresult !== 2'b00)
      begin err++; $display("FAIL simul_pulses: pulses=%0d mr=%b exp 1/00", pulses, matchresult); end
  endtask

  task automatic test_late_second();
    step(1, 2'b10, 0, 0);
    vec++; if (obs !== expv) begin err++; $display("FAIL late_first: obs=%b exp=%b", obs, expv); end
    step(1, 2'b01, 0, 0);
    vec++; if (obs !== expv || p1_ack !== 1'b0) begin err++; $display("FAIL late_dup: obs=%b exp=%b", obs, expv); end
    step(0, 0, 0, 0);
    step(0, 0, 1, 2'b11);
    vec++; if (obs !== expv || matchresult !== 2'b11)
      begin err++; $display("FAIL late_judge: obs=%b exp=%b", obs, expv); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      vec++; if (obs !== expv) begin err++; $display("FAIL late_post%0d: obs=%b exp=%b", i, obs, expv); end
    end
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 1, 2'b01);
      for (int i = 0; i < TO - 1; i++) begin
        step(0, 0, 0, 0);
        vec++; if (obs !== expv || matchresult !== 2'b00 || busy !== 1'b1)
          begin err++; $display("FAIL to_wait%0d_%0d: obs=%b exp=%b", k, i, obs, expv); end
      end
      // k=0: nobody answers -> forfeit; k=1: answer lands on the timeout edge
      if (k == 0) step(0, 0, 0, 0);
      else        step(1, 2'b01, 0, 0);
      vec++; if (obs !== expv || matchresult !== ((k == 0) ? 2'b11 : 2'b01))
        begin err++; $display("FAIL to_edge%0d: obs=%b exp=%b", k, obs, expv); end
      for (int i = 0; i < 3; i++) begin
        step(0, 0, 0, 0);
        vec++; if (obs !== expv) begin err++; $display("FAIL to_post%0d_%0d: obs=%b exp=%b", k, i, obs, expv); end
      end
    end
  endtask

  task automatic test_reject();
    step(1, 2'b00, 1, 2'b00);
    vec++; if (obs !== expv || busy !== 1'b0) begin err++; $display("FAIL rej_zero: obs=%b exp=%b", obs, expv); end
    step(1, 2'b01, 1, 2'b10);
    step(1, 2'b11, 1, 2'b11);
    vec++; if (obs !== expv || round_pulse !== 1'b1) begin err++; $display("FAIL rej_pulse: obs=%b exp=%b", obs, expv); end
    step(1, 2'b10, 1, 2'b01);
    vec++; if (obs !== expv || {p1_ack, p2_ack} !== 2'b00) begin err++; $display("FAIL rej_inpulse: obs=%b exp=%b", obs, expv); end
    step(1, 2'b10, 1, 2'b01);
    vec++; if (obs !== expv || busy !== 1'b0) begin err++; $display("FAIL rej_after: obs=%b exp=%b", obs, expv); end
  endtask

  task automatic test_game_over();
    int pulses = 0;
    step(1, 2'b11, 1, 2'b11);
    step(0, 0, 0, 0); pulses += round_pulse;
    step(0, 0, 0, 0); pulses += round_pulse;
    game_over = 1'b1;
    step(0, 0, 0, 0); pulses += round_pulse;
    for (int i = 0; i < 3; i++) begin
      step(1, 2'b01, 1, 2'b10); pulses += round_pulse;
      vec++; if (obs !== expv || busy !== 1'b0)
        begin err++; $display("FAIL go_block%0d: obs=%b exp=%b", i, obs, expv); end
    end
    vec++; if (pulses != 1) begin err++; $display("FAIL go_pulses: got %0d exp 1", pulses); end
    game_over = 1'b0;
  endtask

  task automatic test_reset_mid_round();
    step(1, 2'b01, 1, 2'b01);
    step(0, 0, 0, 0);
    vec++; if (obs !== expv || round_pulse !== 1'b1) begin err++; $display("FAIL rst_pre: obs=%b exp=%b", obs, expv); end
    resetn = 1'b1; mreset();
    #1;
    vec++; if (obs !== 6'b0) begin err++; $display("FAIL rst_mid: obs=%b exp=000000", obs); end
    @(negedge clk);
    resetn = 1'b0;
    step(1, 2'b10, 1, 2'b11);
    vec++; if (obs !== expv || matchresult !== 2'b11) begin err++; $display("FAIL rst_next: obs=%b exp=%b", obs, expv); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      vec++; if (obs !== expv) begin err++; $display("FAIL rst_post%0d: obs=%b exp=%b", i, obs, expv); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) game_over = ~game_over;
      step(($urandom_range(0, 3) == 0), 2'($urandom), ($urandom_range(0, 5) == 0), 2'($urandom));
      vec++; if (obs !== expv) begin err++; $display("FAIL rand%0d: obs=%b exp=%b", i, obs, expv); end
    end
    game_over = 1'b0;
  endtask

  initial begin
    mreset();
    @(negedge clk);
    test_reset();
    test_simultaneous();
    test_late_second();
    test_timeout();
    test_reject();
    test_game_over();
    test_reset_mid_round();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end
endmodule

// File: doc/rps_round_judge.md
Name: rps_round_judge

Overview:
- Upstream of the score counter: collects one rock/paper/scissors move from each player per round and judges the round.
- Drives the 2-bit match result code plus a one-cycle round strobe, which the score counter uses as its counting clock.
- A player who fails to answer within a timeout after the opponent has submitted forfeits the round.

Parameters:
TIMEOUT_CYCLES, 1000, cycles to wait for the second move after the first is accepted; range 2..2^CW
CW, 10, width of the timeout counter

Ports:
clk  input  1  system clock; all state changes on posedge
resetn  input  1  asynchronous, active-high reset
p1_valid  input  1  player 1 offers p1_move this cycle
p1_move  input  2  01 rock, 10 paper, 11 scissors, 00 invalid
p2_valid  input  1  player 2 offers p2_move this cycle
p2_move  input  2  same encoding as p1_move
game_over  input  1  level from downstream; blocks start of new rounds
p1_ack  output  1  one-cycle pulse: player 1 move accepted
p2_ack  output  1  one-cycle pulse: player 2 move accepted
matchresult  output  2  00 none, 01 draw, 10 player 1 wins, 11 player 2 wins
round_pulse  output  1  one-cycle strobe marking a completed round
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, resetn=1):
  - state IDLE, timeout counter 0, latched moves 00.
  - All outputs 0: matchresult=00, round_pulse=0, p1_ack=0, p2_ack=0, busy=0.
- All outputs are registered.
- Acceptance:
  - A player's offer is accepted on a posedge when valid=1, move!=00, that player has no move latched this round, and state is IDLE/HAVE1/HAVE2.
  - Its ack is high for the cycle after the accepting edge.
  - Rejected offers (move 00, duplicate, wrong state) give no ack and cause no state change.
- States:
  - IDLE:
    - game_over=1: all offers ignored.
    - Only p1 accepted -> HAVE1. Only p2 accepted -> HAVE2.
    - Both accepted on the same edge -> JUDGE.
  - HAVE1 / HAVE2:
    - Counter cleared on entry, +1 per cycle.
    - Other player accepted -> JUDGE.
    - Otherwise, when counter==TIMEOUT_CYCLES-1 -> JUDGE with a forfeit result: HAVE1 gives 10, HAVE2 gives 11.
    - Submission and timeout on the same edge: the submission wins and the round is judged normally.
  - JUDGE: matchresult is loaded on the edge entering JUDGE; next edge -> PULSE.
  - PULSE: round_pulse=1 for exactly this cycle; next edge -> HOLD.
  - HOLD: round_pulse=0, matchresult still held; next edge -> IDLE, matchresult=00.
- Judging rule:
  - Equal moves -> 01.
  - Player 1 wins with rock vs scissors, paper vs rock, scissors vs paper -> 10.
  - Otherwise -> 11.
- Output timing:
  - matchresult is stable from one cycle before round_pulse rises until one cycle after it falls.
  - The downstream negedge counting and matchresult gating are therefore glitch-free.
- Offers made during JUDGE/PULSE/HOLD are ignored (no ack, not carried into the next round).
- game_over rising mid-round: the round completes normally; the block then stays in IDLE.
- Reset mid-round: immediate return to the reset state; no round_pulse is emitted.
- Latency: second acceptance at edge E0 -> matchresult valid after E0, round_pulse high between E1 and E2, matchresult=00 after E3. Minimum round = 4 cycles.

Test Plan:
- Reset, then p1=01 and p2=11 offered on the same edge -> both acks high next cycle; matchresult=10 one cycle before round_pulse; single round_pulse; matchresult 00 two cycles after the pulse.
- p1=10 accepted, p2=11 accepted 3 cycles later (TIMEOUT_CYCLES=8) -> matchresult=11, one round_pulse; p1 re-offers while in HAVE1 -> no second p1_ack, latched move unchanged.
- p2=01 accepted, p1 silent, TIMEOUT_CYCLES=8 -> JUDGE entered exactly 8 edges after acceptance with forfeit matchresult=11; p1 offer on that same edge instead -> normal judge, 01 vs 01 gives matchresult=01.
- Offers with move=00 and offers during PULSE -> no ack, no state change, round count at downstream unchanged.
- game_over=1 asserted during HOLD -> round finishes with one round_pulse; later offers get no ack; busy stays 0.
- resetn pulsed while in PULSE -> round_pulse drops immediately, matchresult=00, state IDLE; next round proceeds normally.
